// File: rtl/atm_otp_responder_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
//
// Shared definitions for the ATM OTP responder:
//   - otp_state_e     : responder FSM states
//   - OTP_* codes     : response codes returned to the ATM controller
//   - OTP_W_DEFAULT   : default OTP width
//   - OTP_ZERO_SUB    : value used when the mixed OTP would be all zeros
//   - LFSR_W/LFSR_TAPS: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
//   - lfsr16_next()   : single-step helper for the LFSR
// -----------------------------------------------------------------------------
package atm_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_ENTRY = 2'd2,
        RESPOND    = 2'd3
    } otp_state_e;

    localparam logic [1:0] OTP_OK       = 2'b00;
    localparam logic [1:0] OTP_TOO_MANY = 2'b01;
    localparam logic [1:0] OTP_TIMEOUT  = 2'b10;
    localparam logic [1:0] OTP_ABORTED  = 2'b11;

    localparam int         OTP_W_DEFAULT = 6;
    localparam logic [5:0] OTP_ZERO_SUB  = 6'h2A;

    localparam int          LFSR_W    = 16;
    // Exponents 16,14,13,11 map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift left; the new LSB is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/atm_otp_responder_lfsr.sv
// -----------------------------------------------------------------------------
// otp_lfsr
//
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). It advances
// on every rising clock edge and restarts from SEED on reset.
//
// Parameters:
//   SEED    : reset value, must be non-zero (all-zero is a lock-up state)
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   lfsr_o  : current LFSR contents
// -----------------------------------------------------------------------------
module otp_lfsr
    import atm_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr16_next(lfsr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/atm_otp_responder.sv
// -----------------------------------------------------------------------------
// atm_otp_responder
//
// Responder side of the ATM high-value withdrawal OTP handshake. On a
// controller request it mixes the free-running LFSR with the account index
// to form an OTP, strobes it to the customer device, checks customer
// entries against it with a limited number of tries, and returns a
// single-cycle response code to the controller.
//
// Optional build macro:
//   ATM_OTP_TIMEOUT_EN : enables a WAIT_ENTRY timeout of TIMEOUT_CYCLES
//                        cycles (response code 10). Without it the block
//                        waits for an entry or abort indefinitely.
//
// Parameters:
//   OTP_W          : OTP width in bits (<= 16)
//   MAX_TRIES      : wrong entries allowed before lockout (1..3)
//   TIMEOUT_CYCLES : WAIT_ENTRY cycles before timeout (timeout build only)
//   LFSR_SEED      : LFSR reset value (non-zero)
//
// Ports:
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   req_valid_i    : controller requests an OTP session
//   req_ready_o    : high only in IDLE (decoded from state)
//   acc_index_i    : account index, sampled on the accept cycle
//   abort_i        : controller cancel, wins over any entry
//   otp_out_o      : OTP shown to the customer device
//   otp_valid_o    : one-cycle strobe, otp_out_o is new
//   entry_valid_i  : customer entry strobe
//   entry_otp_i    : customer-entered OTP
//   tries_left_o   : remaining wrong entries allowed
//   resp_valid_o   : one-cycle response strobe
//   resp_code_o    : 00 OK, 01 TOO_MANY_TRIES, 10 TIMEOUT, 11 ABORTED
// -----------------------------------------------------------------------------
module atm_otp_responder
    import atm_pkg::*;
#(
    parameter int          OTP_W          = OTP_W_DEFAULT,
    parameter int          MAX_TRIES      = 3,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       acc_index_i,
    input  logic             abort_i,
    output logic [OTP_W-1:0] otp_out_o,
    output logic             otp_valid_o,
    input  logic             entry_valid_i,
    input  logic [OTP_W-1:0] entry_otp_i,
    output logic [1:0]       tries_left_o,
    output logic             resp_valid_o,
    output logic [1:0]       resp_code_o
);

    // -------------------------------------------------------------------------
    // Free-running OTP source
    // -------------------------------------------------------------------------
    logic [LFSR_W-1:0] lfsr;

    otp_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lfsr_o (lfsr)
    );

    // Candidate OTP for this cycle; an all-zero OTP is replaced because a
    // cleared otp_out_o of 0 would be indistinguishable from "no OTP".
    logic [OTP_W-1:0] otp_mix;
    logic [OTP_W-1:0] otp_new;

    always_comb begin
        otp_mix = lfsr[OTP_W-1:0] ^ OTP_W'(acc_index_i);
        otp_new = (otp_mix == '0) ? OTP_W'(OTP_ZERO_SUB) : otp_mix;
    end

    generate
        if (OTP_W < LFSR_W) begin : g_lfsr_spare
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr[LFSR_W-1:OTP_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    otp_state_e       state_q,      state_d;
    logic [OTP_W-1:0] otp_q,        otp_d;
    logic             otp_valid_q,  otp_valid_d;
    logic [1:0]       tries_q,      tries_d;
    logic             resp_valid_q, resp_valid_d;
    logic [1:0]       resp_code_q,  resp_code_d;

    // -------------------------------------------------------------------------
    // Decision terms for the current cycle, in priority order:
    // abort, then a customer entry, then the timeout.
    // -------------------------------------------------------------------------
    logic in_session;
    logic abort_hit;
    logic entry_hit;
    logic entry_match;
    logic entry_lockout;
    logic timeout_hit;

    always_comb begin
        in_session    = (state_q == ISSUE) || (state_q == WAIT_ENTRY);
        abort_hit     = in_session && abort_i;
        entry_hit     = (state_q == WAIT_ENTRY) && !abort_i && entry_valid_i;
        entry_match   = entry_hit && (entry_otp_i == otp_q);
        // The last allowed wrong entry ends the session.
        entry_lockout = entry_hit && !entry_match && (tries_q == 2'd1);
    end

`ifdef ATM_OTP_TIMEOUT_EN
    // Counts WAIT_ENTRY cycles; zero in the first WAIT_ENTRY cycle. Wrong
    // entries keep the session in WAIT_ENTRY and so do not restart it.
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    always_comb begin
        timeout_hit = (state_q == WAIT_ENTRY) && !abort_i && !entry_valid_i
                      && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_d       = '0;
        if ((state_q == WAIT_ENTRY) && (state_d == WAIT_ENTRY)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;

    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = abort_hit ? RESPOND : WAIT_ENTRY;
            end
            WAIT_ENTRY: begin
                if (abort_hit || entry_match || entry_lockout || timeout_hit) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        otp_d        = otp_q;
        tries_d      = tries_q;
        resp_code_d  = resp_code_q;
        // Strobes mark the first (and only) cycle of their state.
        otp_valid_d  = (state_d == ISSUE);
        resp_valid_d = (state_d == RESPOND);

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    otp_d   = otp_new;
                    tries_d = 2'(MAX_TRIES);
                end
            end
            ISSUE: begin
                if (abort_hit) begin
                    resp_code_d = OTP_ABORTED;
                end
            end
            WAIT_ENTRY: begin
                if (abort_hit) begin
                    resp_code_d = OTP_ABORTED;
                end else if (entry_match) begin
                    resp_code_d = OTP_OK;
                end else if (entry_hit) begin
                    tries_d = tries_q - 2'd1;
                    if (entry_lockout) begin
                        resp_code_d = OTP_TOO_MANY;
                    end
                end else if (timeout_hit) begin
                    resp_code_d = OTP_TIMEOUT;
                end
            end
            RESPOND: begin
                otp_d   = '0;
                tries_d = 2'd0;
            end
            default: begin
                otp_d   = '0;
                tries_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            otp_q        <= '0;
            otp_valid_q  <= 1'b0;
            tries_q      <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= OTP_OK;
        end else begin
            otp_q        <= otp_d;
            otp_valid_q  <= otp_valid_d;
            tries_q      <= tries_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign otp_out_o    = otp_q;
    assign otp_valid_o  = otp_valid_q;
    assign tries_left_o = tries_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_code_o  = resp_code_q;

endmodule

// File: tb/tb_atm_otp_responder.sv
// -----------------------------------------------------------------------------
// tb_atm_otp_responder
//
// Directed and randomized sessions against atm_otp_responder. Expected OTPs
// come from a polynomial-driven LFSR reference evaluated from the number of
// clock edges since reset; expected responses come from the session rules.
// Honours ATM_OTP_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_atm_otp_responder;

    localparam int          OTP_W     = 6;
    localparam int          MAX_TRIES = 3;
    localparam int          TMO       = 16;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       acc_index = 4'd0;
    logic             abort = 1'b0;
    logic [OTP_W-1:0] otp_out;
    logic             otp_valid;
    logic             entry_valid = 1'b0;
    logic [OTP_W-1:0] entry_otp = '0;
    logic [1:0]       tries_left;
    logic             resp_valid;
    logic [1:0]       resp_code;

    int checks = 0;
    int errors = 0;
    int edge_cnt;

    atm_otp_responder #(
        .OTP_W          (OTP_W),
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TMO),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .acc_index_i    (acc_index),
        .abort_i        (abort),
        .otp_out_o      (otp_out),
        .otp_valid_o    (otp_valid),
        .entry_valid_i  (entry_valid),
        .entry_otp_i    (entry_otp),
        .tries_left_o   (tries_left),
        .resp_valid_o   (resp_valid),
        .resp_code_o    (resp_code)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was released: the LFSR has advanced
    // exactly this many times.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifted left, feedback into LSB.
    function automatic logic [15:0] lfsr_ref(input int n);
        int          taps [4] = '{16, 14, 13, 11};
        logic [15:0] s;
        logic        fb;
        s = SEED;
        for (int k = 0; k < n; k++) begin
            fb = 1'b0;
            foreach (taps[t]) fb = fb ^ s[taps[t] - 1];
            s = {s[14:0], fb};
        end
        return s;
    endfunction

    function automatic logic [5:0] otp_ref(input int n, input logic [3:0] acc);
        logic [15:0] l;
        logic [5:0]  o;
        l = lfsr_ref(n);
        o = l[5:0] ^ {2'b00, acc};
        if (o == 6'd0) o = 6'h2A;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a session from IDLE. Returns in the first WAIT_ENTRY cycle.
    task automatic accept(input logic [3:0] acc, output logic [5:0] otp);
        abort = 1'b1;                       // ignored in IDLE
        tick();
        abort = 1'b0;
        chk("idle_abort_ready", 32'(req_ready), 32'd1);
        chk("idle_abort_resp", 32'(resp_valid), 32'd0);
        otp = otp_ref(edge_cnt, acc);
        req_valid = 1'b1;
        acc_index = acc;
        tick();                             // ISSUE
        req_valid = 1'b0;
        chk("issue_otp_valid", 32'(otp_valid), 32'd1);
        chk("issue_otp", 32'(otp_out), 32'(otp));
        chk("issue_tries", 32'(tries_left), 32'(MAX_TRIES));
        chk("issue_ready", 32'(req_ready), 32'd0);
        entry_valid = 1'b1;                 // entry outside WAIT_ENTRY is ignored
        entry_otp   = otp;
        tick();                             // first WAIT_ENTRY cycle
        entry_valid = 1'b0;
        chk("wait_otp_valid", 32'(otp_valid), 32'd0);
        chk("wait_no_resp", 32'(resp_valid), 32'd0);
    endtask

    // Called in the RESPOND cycle: check the strobe, then the return to IDLE.
    task automatic finish_resp(input string tag, input logic [1:0] code);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_code"}, 32'(resp_code), 32'(code));
        chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
        tick();
        chk({tag, "_resp_once"}, 32'(resp_valid), 32'd0);
        chk({tag, "_otp_clr"}, 32'(otp_out), 32'd0);
        chk({tag, "_tries_clr"}, 32'(tries_left), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One session: n_wrong wrong entries, then the correct one unless locked
    // out. If abort_idx matches an entry step, abort is raised with that entry.
    task automatic session(input logic [3:0] acc, input int n_wrong, input int abort_idx);
        logic [5:0] otp;
        logic [5:0] flip;
        logic [1:0] code;
        int         tries;
        int         stages;
        bit         done;
        accept(acc, otp);
        tries  = MAX_TRIES;
        done   = 1'b0;
        code   = 2'b00;
        stages = (n_wrong >= MAX_TRIES) ? MAX_TRIES : n_wrong + 1;
        for (int i = 0; i < stages && !done; i++) begin
            repeat ($urandom_range(0, 2)) begin
                req_valid = 1'($urandom_range(0, 1));   // must be ignored
                acc_index = 4'($urandom_range(0, 15));
                entry_otp = 6'($urandom);
                tick();
                req_valid = 1'b0;
                chk("gap_no_resp", 32'(resp_valid), 32'd0);
                chk("gap_otp_hold", 32'(otp_out), 32'(otp));
            end
            entry_valid = 1'b1;
            if (i == abort_idx) begin
                abort     = 1'b1;
                entry_otp = otp;
                tick();
                code = 2'b11;
                done = 1'b1;
            end else if (i < n_wrong) begin
                flip      = 6'($urandom_range(1, 63));
                entry_otp = otp ^ flip;
                tick();
                tries--;
                if (tries == 0) begin
                    chk("lock_tries", 32'(tries_left), 32'd0);
                    code = 2'b01;
                    done = 1'b1;
                end else begin
                    chk("wrong_no_resp", 32'(resp_valid), 32'd0);
                    chk("wrong_tries", 32'(tries_left), 32'(tries));
                end
            end else begin
                entry_otp = otp;
                tick();
                code = 2'b00;
                done = 1'b1;
            end
            entry_valid = 1'b0;
            abort       = 1'b0;
        end
        finish_resp("sess", code);
        $display("session acc=%0d otp=%02h wrong=%0d abort_idx=%0d code=%0d",
                 acc, otp, n_wrong, abort_idx, code);
    endtask

    initial begin
        logic [5:0]  first_otp;
        logic [5:0]  otp;
        logic [15:0] l;
        bit          found;

        // ---------------- power-on reset ----------------
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_otp", 32'(otp_out), 32'd0);
        chk("rst_otp_valid", 32'(otp_valid), 32'd0);
        chk("rst_tries", 32'(tries_left), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_code", 32'(resp_code), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // First OTP after power-on for account 0, then a correct entry.
        accept(4'd0, first_otp);
        entry_valid = 1'b1;
        entry_otp   = first_otp;
        tick();
        entry_valid = 1'b0;
        finish_resp("first", 2'b00);
        $display("session acc=0 otp=%02h first after reset code=0", first_otp);

        // ---------------- directed sessions ----------------
        session(4'd4, 0, -1);           // correct entry
        session(4'd4, 1, -1);           // one retry then pass
        session(4'd7, 3, -1);           // lockout
        session(4'd2, 0, 0);            // abort with correct entry
        session(4'd9, 2, 1);            // abort after one wrong entry

        // ---------------- zero-substitution boundary ----------------
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            l = lfsr_ref(edge_cnt + 1);     // accept() spends one idle cycle first
            if (l[5:4] == 2'b00) found = 1'b1;
            else tick();
        end
        chk("zero_search", 32'(found), 32'd1);
        if (found) begin
            accept(l[3:0], otp);
            chk("zero_sub_otp", 32'(otp_out), 32'h2A);
            entry_valid = 1'b1;
            entry_otp   = 6'h2A;
            tick();
            entry_valid = 1'b0;
            finish_resp("zero", 2'b00);
            $display("session acc=%0d otp=%02h zero-substitute code=0", l[3:0], otp);
        end

        // ---------------- timeout / indefinite wait ----------------
`ifdef ATM_OTP_TIMEOUT_EN
        accept(4'd5, otp);              // WAIT_ENTRY index 0
        for (int c = 0; c < TMO; c++) begin
            if (c == 5) begin           // wrong entry must not restart the count
                entry_valid = 1'b1;
                entry_otp   = otp ^ 6'h3F;
            end
            tick();
            entry_valid = 1'b0;
            if (c < TMO - 1) chk("tmo_wait", 32'(resp_valid), 32'd0);
        end
        finish_resp("tmo", 2'b10);
        $display("session acc=5 otp=%02h timeout code=2", otp);

        accept(4'd6, otp);
        repeat (TMO - 1) tick();        // expiry cycle
        abort       = 1'b1;
        entry_valid = 1'b1;
        entry_otp   = otp;
        tick();
        abort       = 1'b0;
        entry_valid = 1'b0;
        finish_resp("tmo_abort", 2'b11);
        $display("session acc=6 otp=%02h abort at expiry code=3", otp);

        accept(4'd8, otp);
        repeat (TMO - 1) tick();
        entry_valid = 1'b1;
        entry_otp   = otp;
        tick();
        entry_valid = 1'b0;
        finish_resp("tmo_entry", 2'b00);
        $display("session acc=8 otp=%02h entry at expiry code=0", otp);
`else
        accept(4'd5, otp);
        begin
            int seen = 0;
            repeat (100) begin
                tick();
                if (resp_valid) seen++;
            end
            chk("no_tmo_resp", 32'(seen), 32'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        finish_resp("no_tmo_abort", 2'b11);
        $display("session acc=5 otp=%02h waited 100 cycles then abort code=3", otp);
`endif

        // ---------------- randomized sessions ----------------
        for (int s = 0; s < 16; s++) begin
            int nw;
            int ai;
            nw = $urandom_range(0, MAX_TRIES);
            ai = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_TRIES - 1) : -1;
            session(4'($urandom_range(0, 15)), nw, ai);
        end

        // ---------------- reset mid-session ----------------
        accept(4'd9, otp);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_otp", 32'(otp_out), 32'd0);
        chk("mid_rst_otp_valid", 32'(otp_valid), 32'd0);
        chk("mid_rst_tries", 32'(tries_left), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_code", 32'(resp_code), 32'd0);
        @(negedge clk);
        chk("mid_rst_hold_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        accept(4'd0, otp);
        chk("rst_replay_otp", 32'(otp), 32'(first_otp));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        finish_resp("replay", 2'b11);
        $display("session acc=0 otp=%02h replay after reset code=3", otp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
